mem_stage: RTL and testbench

Memory-stage controller that consumes the EX/MEM pipeline register outputs (`*_M` signals) and runs the data-memory access. Non-memory instructions pass straight into the MEM/WB register; loads and stores run a request/acknowledge transaction with the data memory while the stage stalls upstream. It drives the writeback-stage signals (`*_W`), selecting the loaded word or the ALU result.

---
 rtl/mem_stage.sv | 150 +++++++++++++++
 tb/tb_mem_stage.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-stage controller: passes ALU results into MEM/WB and runs a
// request/acknowledge data-memory transaction for loads and stores.
//
// state  | meaning
// IDLE   | pass non-memory ops through; detect a memory op and stall
// ACCESS | mem_req high, wait for mem_ack or timeout
// DONE   | release stall, write back the finished memory op once
module mem_stage #(
  parameter int N   = 32,
  parameter int M   = 4,
  parameter int TMO = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pcload_M,
  input  logic         regw_M,
  input  logic         memw_M,
  input  logic         regmem_M,
  input  logic [M-1:0] regScr_M,
  input  logic [N-1:0] ALUrslt_M,
  input  logic [N-1:0] address_M,
  output logic         mem_req,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  input  logic [N-1:0] mem_rdata,
  input  logic         mem_ack,
  output logic         stall_M,
  output logic         pcload_W,
  output logic         regw_W,
  output logic [M-1:0] regScr_W,
  output logic [N-1:0] result_W,
  output logic         mem_err
);

  localparam int CW = (TMO > 1) ? $clog2(TMO) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [N-1:0]   ldata, ldata_nxt;
  logic           tmo, tmo_nxt;
  logic           err_nxt;
  logic           pcload_nxt, regw_nxt;
  logic [M-1:0]   regscr_nxt;
  logic [N-1:0]   result_nxt;

  logic mem_op, is_load;

  // A store wins when both memw_M and regmem_M are set.
  assign mem_op  = memw_M | regmem_M;
  assign is_load = regmem_M & ~memw_M;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    ldata_nxt  = ldata;
    tmo_nxt    = tmo;
    err_nxt    = mem_err;
    pcload_nxt = pcload_W;
    regw_nxt   = regw_W;
    regscr_nxt = regScr_W;
    result_nxt = result_W;
    stall_M    = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;

    case (state)
      IDLE: begin
        if (mem_op) begin
          stall_M    = 1'b1;
          pcload_nxt = 1'b0;
          regw_nxt   = 1'b0;
          cnt_nxt    = '0;
          state_nxt  = ACCESS;
        end else begin
          pcload_nxt = pcload_M;
          regw_nxt   = regw_M;
          regscr_nxt = regScr_M;
          result_nxt = ALUrslt_M;
        end
      end

      ACCESS: begin
        stall_M    = 1'b1;
        mem_req    = 1'b1;
        mem_we     = memw_M;
        mem_addr   = address_M;
        mem_wdata  = memw_M ? ALUrslt_M : '0;
        pcload_nxt = 1'b0;
        regw_nxt   = 1'b0;
        if (mem_ack) begin
          if (is_load) ldata_nxt = mem_rdata;
          state_nxt = DONE;
        end else if (cnt == CW'(TMO - 1)) begin
          err_nxt   = 1'b1;
          tmo_nxt   = 1'b1;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      DONE: begin
        // Instruction is still on *_M here; returning to IDLE unconditionally
        // stops it being issued a second time.
        pcload_nxt = pcload_M;
        regw_nxt   = regw_M & ~tmo;
        regscr_nxt = regScr_M;
        result_nxt = is_load ? ldata : ALUrslt_M;
        tmo_nxt    = 1'b0;
        state_nxt  = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      ldata    <= '0;
      tmo      <= 1'b0;
      mem_err  <= 1'b0;
      pcload_W <= 1'b0;
      regw_W   <= 1'b0;
      regScr_W <= '0;
      result_W <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      ldata    <= ldata_nxt;
      tmo      <= tmo_nxt;
      mem_err  <= err_nxt;
      pcload_W <= pcload_nxt;
      regw_W   <= regw_nxt;
      regScr_W <= regscr_nxt;
      result_W <= result_nxt;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed and random instructions checked against a
// transaction-level model of stall/request counts and writeback values.
module tb_mem_stage;

  localparam int N   = 32;
  localparam int M   = 4;
  localparam int TMO = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         pcload_M, regw_M, memw_M, regmem_M;
  logic [M-1:0] regScr_M;
  logic [N-1:0] ALUrslt_M, address_M;
  logic         mem_req, mem_we;
  logic [N-1:0] mem_addr, mem_wdata, mem_rdata;
  logic         mem_ack, stall_M;
  logic         pcload_W, regw_W;
  logic [M-1:0] regScr_W;
  logic [N-1:0] result_W;
  logic         mem_err;

  mem_stage #(.N(N), .M(M), .TMO(TMO)) dut (
    .clk(clk), .rst(rst),
    .pcload_M(pcload_M), .regw_M(regw_M), .memw_M(memw_M), .regmem_M(regmem_M),
    .regScr_M(regScr_M), .ALUrslt_M(ALUrslt_M), .address_M(address_M),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall_M(stall_M),
    .pcload_W(pcload_W), .regw_W(regw_W), .regScr_W(regScr_W),
    .result_W(result_W), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference state: last successfully loaded word, sticky error
  logic [N-1:0] m_ldata = '0;
  logic         m_err   = 1'b0;
  bit           spur    = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // k = ACCESS cycle carrying the ack (1-based); 0 or >TMO means never acked
  task automatic run_instr(input logic pcl, input logic rw, input logic mw, input logic rm,
                           input logic [M-1:0] scr, input logic [N-1:0] alu,
                           input logic [N-1:0] addr, input int k, input logic [N-1:0] rdata);
    bit memop, ld, timeout, done, s, r;
    int n_stall, n_req, cyc, exp_req;
    logic [N-1:0] exp_res;
    memop   = mw | rm;
    ld      = rm & ~mw;
    timeout = memop && (k < 1 || k > TMO);
    exp_req = !memop ? 0 : (timeout ? TMO : k);
    n_stall = 0; n_req = 0; cyc = 0; done = 0;
    @(negedge clk);
    pcload_M = pcl; regw_M = rw; memw_M = mw; regmem_M = rm;
    regScr_M = scr; ALUrslt_M = alu; address_M = addr;
    while (!done && cyc < TMO + 8) begin
      #1;
      s = stall_M;
      r = mem_req;
      if (r) begin
        n_req++;
        chk("mem_we", {31'd0, mem_we}, {31'd0, mw});
        chk("mem_addr", mem_addr, addr);
        chk("mem_wdata", mem_wdata, mw ? alu : 32'd0);
        if (n_req == k) begin
          mem_ack = 1'b1; mem_rdata = rdata;
        end else begin
          mem_ack = 1'b0; mem_rdata = $urandom;
        end
      end else begin
        chk("idle_bus", {mem_we, mem_addr | mem_wdata}, 33'd0);
        mem_ack   = spur ? 1'b1 : ($urandom_range(0, 3) == 0);
        mem_rdata = 32'hFFFF_FFFF;
      end
      if (s) n_stall++;
      @(posedge clk); #1;
      if (s) chk("bubble", {30'd0, pcload_W, regw_W}, 32'd0);
      else   done = 1;
      if (!done) @(negedge clk);
      cyc++;
    end
    mem_ack = 1'b0;
    if (!done) chk("cycle_budget", 32'd0, 32'd1);
    chk("req_cycles", 32'(n_req), 32'(exp_req));
    chk("stall_cycles", 32'(n_stall), memop ? 32'(exp_req + 1) : 32'd0);
    if (ld && !timeout) m_ldata = rdata;
    exp_res = ld ? m_ldata : alu;
    if (timeout) m_err = 1'b1;
    chk("pcload_W", {31'd0, pcload_W}, {31'd0, pcl});
    chk("regw_W", {31'd0, regw_W}, {31'd0, rw & ~timeout});
    chk("regScr_W", 32'(regScr_W), 32'(scr));
    chk("result_W", result_W, exp_res);
    chk("mem_err", {31'd0, mem_err}, {31'd0, m_err});
  endtask

  initial begin
    rst = 1'b1;
    pcload_M = 0; regw_M = 0; memw_M = 0; regmem_M = 0;
    regScr_M = '0; ALUrslt_M = '0; address_M = '0;
    mem_ack = 0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_bus", {mem_we, mem_addr | mem_wdata}, 33'd0);
    chk("rst_stall", {31'd0, stall_M}, 32'd0);
    chk("rst_W", {pcload_W, regw_W, regScr_W, result_W}, '0);
    chk("rst_err", {31'd0, mem_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // ALU op, load with ack in 3rd ACCESS cycle, store with immediate ack
    run_instr(0, 1, 0, 0, 4'h3, 32'h0000_00A5, 32'h0, 0, 32'h0);
    run_instr(0, 1, 0, 1, 4'h7, 32'h5555_0000, 32'h40, 3, 32'hDEAD_BEEF);
    run_instr(0, 0, 1, 1, 4'h2, 32'h1234_5678, 32'h80, 1, 32'hCAFE_0000);
    // Ack on the last allowed cycle is not a timeout
    run_instr(1, 1, 0, 1, 4'h9, 32'h0, 32'h44, TMO, 32'h0BAD_F00D);
    // Timeout, then confirm mem_err stays set on a following op
    run_instr(0, 1, 0, 1, 4'h5, 32'h7777_7777, 32'h48, 0, 32'h0);
    run_instr(1, 1, 0, 0, 4'hA, 32'h0000_1111, 32'h0, 0, 32'h0);

    // Reset in the 2nd ACCESS cycle aborts with no writeback
    @(negedge clk);
    pcload_M = 1; regw_M = 1; memw_M = 0; regmem_M = 1;
    regScr_M = 4'hC; ALUrslt_M = 32'h1; address_M = 32'h50; mem_ack = 0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("pre_rst_req", {31'd0, mem_req}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_req", {31'd0, mem_req}, 32'd0);
    chk("abort_W", {pcload_W, regw_W, regScr_W, result_W}, '0);
    chk("abort_err", {31'd0, mem_err}, 32'd0);
    m_ldata = '0; m_err = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    pcload_M = 0; regw_M = 0; regmem_M = 0; regScr_M = '0; ALUrslt_M = '0; address_M = '0;
    mem_ack = 1'b1; mem_rdata = 32'h2222_2222;
    @(posedge clk); #1;
    chk("late_ack_regw", {30'd0, pcload_W, regw_W}, 32'd0);
    @(negedge clk);
    mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("late_ack_idle", {30'd0, mem_req, regw_W}, 32'd0);

    // Spurious acks during ALU ops, then a load returning 1
    spur = 1'b1;
    run_instr(0, 1, 0, 0, 4'h1, 32'h0000_0010, 32'h0, 0, 32'h0);
    run_instr(0, 1, 0, 0, 4'h2, 32'h0000_0020, 32'h0, 0, 32'h0);
    spur = 1'b0;
    run_instr(0, 1, 0, 1, 4'h4, 32'h0000_0030, 32'h60, 2, 32'h0000_0001);

    // Random back-to-back mix
    for (int i = 0; i < 40; i++) begin
      int kk, sel;
      logic mw, rm;
      sel = $urandom_range(0, 3);
      mw  = (sel == 2) || (sel == 3 && $urandom_range(0, 1) == 1);
      rm  = (sel == 1) || (sel == 3);
      kk  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 5);
      run_instr(1'($urandom), 1'($urandom), mw, rm, 4'($urandom),
                $urandom, $urandom, kk, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
